usb_serial_recv_fifo: RTL
=========================

// Module: usb_serial_recv_fifo
// PURPOSE
//  Receive-side (host-to-device) buffer for one USB-CDC serial channel.
//  - Accepts bytes from a core OUT endpoint (epXX_data/epXX_valid), which pulses valid and cannot be stalled.
//  - Stores them in a 2^ASIZE-byte RAM.
//  - Presents them to user logic through a first-word-fall-through valid/ready port.
//  - Counts bytes dropped on overflow.
//  - One instance per channel sits between usbfs_core_top and the application.
// PARAMETERS
//  ASIZE        10    log2 of capacity; capacity DEPTH = 2^ASIZE bytes
//  AFULL_LEVEL  992   almost_full asserts when level >= AFULL_LEVEL (must be <= DEPTH)
// PORTS
//  clk           in   1        system clock, 60MHz domain of the USB core
//  rst           in   1        synchronous active-high reset
//  in_data       in   8        received byte from core OUT endpoint
//  in_valid      in   1        1-cycle pulse: in_data is valid; no backpressure exists
//  out_data      out  8        head byte to user
//  out_valid     out  1        out_data holds a byte
//  out_ready     in   1        user accepts; transfer when out_valid & out_ready
//  level         out  ASIZE+1  bytes held, including the output stage (0..DEPTH)
//  almost_full   out  1        level >= AFULL_LEVEL
//  overflow      out  1        sticky: at least one byte dropped since last clear
//  overflow_cnt  out  16       dropped-byte count, saturates at 16'hFFFF
//  clr_overflow  in   1        1-cycle pulse: clear overflow and overflow_cnt
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//  - all pointers = 0; out_valid=0; out_data=8'h00; level=0; almost_full=0; overflow=0; overflow_cnt=0.
//  - RAM contents are not cleared.
//  - Any in_valid during reset is ignored and not counted.
//  Storage:
//  - RAM of DEPTH x 8 with a registered read port (1-cycle read latency), plus one output register.
//  - Pointers wptr/rptr are ASIZE+1 bits and wrap modulo 2^(ASIZE+1).
//  - RAM is empty when wptr==rptr and full when MSBs differ and the low bits are equal.
//  - level = (wptr - rptr) + (bytes in read pipeline/output stage). level is registered and never exceeds DEPTH.
//  Write side:
//  - Byte accepted when in_valid=1 and level < DEPTH at that edge.
//  - When level == DEPTH, the byte is dropped. This applies even if a pop happens in the same cycle.
//  - On a drop: overflow <= 1; overflow_cnt <= overflow_cnt+1, saturating at 16'hFFFF.
//  - Drop and clr_overflow in the same cycle: overflow=1, overflow_cnt=1.
//  Read side (FWFT):
//  - Latency: with the FIFO empty and in_valid sampled at edge k, out_valid=1 after edge k+2, with out_data equal to that byte.
//  - While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
//  - On pop (out_valid & out_ready), the next byte presents on the following cycle if one is already in the read pipeline.
//  - Back-to-back pops therefore sustain 1 byte/cycle once the pipeline is primed. The implementation uses a skid/prefetch stage as needed to meet this.
//  - out_ready while out_valid=0 has no effect.
//  - Bytes exit in exactly the order they were accepted. There is no duplication and no loss other than counted drops.
//  Simultaneous push and pop: level is unchanged, provided the push is not dropped.
//  Flags: almost_full is combinational from the registered level. overflow and overflow_cnt are registered.
//  Reset mid-operation:
//  - Contents are discarded and the block returns to the reset state at that edge.
//  - The first byte after rst deasserts follows the empty-FIFO latency.
// TESTING
//  1. Reset, then single byte 8'hA5 at edge k, out_ready=0 -> out_valid=1 from edge k+2, out_data=A5 held, level=1.
//  2. Burst 0x00..0xFF on consecutive cycles, out_ready=1 continuously -> 256 bytes out in order, 1/cycle after priming, level returns to 0.
//  3. ASIZE=4: push 20 bytes with out_ready=0 -> level=16, almost_full per AFULL_LEVEL, overflow=1, overflow_cnt=4; drain yields the first 16 in order.
//  4. Full (level=16) with push and pop in the same cycle -> push dropped, overflow_cnt+1, level=15; then drop coincident with clr_overflow -> overflow_cnt=1.
//  5. Force overflow_cnt to 16'hFFFE, drop 3 bytes -> overflow_cnt=16'hFFFF; clr_overflow -> 0, overflow=0.
//  6. Random push pulses and random out_ready over 100k cycles, rst pulsed mid-run -> scoreboard order and drop counts match; outputs at reset values the cycle after rst.

Source files
------------

// File: rtl/usb_serial_recv_fifo.sv
// Receive buffer for one USB-CDC serial channel: a non-stallable byte stream from the core OUT
// endpoint goes into a RAM and comes out through a first-word-fall-through port, with overflow counting.
module usb_serial_recv_fifo #(
    parameter int ASIZE       = 10,
    parameter int AFULL_LEVEL = 992
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ASIZE:0]   level,
    output logic             almost_full,
    output logic             overflow,
    output logic [15:0]      overflow_cnt,
    input  logic             clr_overflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_L = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AFULL_L = AFULL_LEVEL[ASIZE:0];

    logic [7:0]     mem [0:DEPTH-1];
    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [7:0]     rd_q;
    logic           rd_valid;

    logic ram_empty;
    logic push;
    logic drop;
    logic pop;
    logic rd_advance;
    logic rd_en;

    // Handshake: a byte leaves when out_valid & out_ready at a clk edge; while out_valid is high
    // and out_ready is low, out_data/out_valid hold. The input side has no ready at all.
    assign ram_empty  = (wptr == rptr);
    assign push       = in_valid && (level != DEPTH_L);
    assign drop       = in_valid && (level == DEPTH_L);
    assign pop        = out_valid && out_ready;
    assign rd_advance = rd_valid && (!out_valid || pop);
    assign rd_en      = !ram_empty && (!rd_valid || rd_advance);

    assign almost_full = (level >= AFULL_L);

    // RAM with registered read port; rd_q holds its value when no read is issued, so it doubles
    // as the skid stage that lets back-to-back pops run at one byte per cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[ASIZE-1:0]] <= in_data;
        end
        if (rd_en) begin
            rd_q <= mem[rptr[ASIZE-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            rd_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            level        <= '0;
            overflow     <= 1'b0;
            overflow_cnt <= 16'h0000;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end

            if (rd_en) begin
                rd_valid <= 1'b1;
            end else if (rd_advance) begin
                rd_valid <= 1'b0;
            end

            if (rd_advance) begin
                out_valid <= 1'b1;
                out_data  <= rd_q;
            end else if (pop) begin
                out_valid <= 1'b0;
            end

            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end

            // A drop coinciding with a clear leaves exactly that one drop recorded.
            if (clr_overflow) begin
                overflow     <= drop;
                overflow_cnt <= drop ? 16'h0001 : 16'h0000;
            end else if (drop) begin
                overflow <= 1'b1;
                if (overflow_cnt != 16'hFFFF) begin
                    overflow_cnt <= overflow_cnt + 16'h0001;
                end
            end
        end
    end

endmodule
